// File: rtl/hearing_aid_pkg.sv
// Shared definitions for the hearing-aid channel scheduler.
// Holds the default widths and the scheduler state encoding.
package hearing_aid_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/hearing_aid_channel_scheduler_rr_arbiter.sv
// Round-robin first-set search over the pending mask, starting at rr_ptr.
// Purely combinational; the scheduler registers everything it derives from the grant.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int PTR_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] pending,
   input  logic [PTR_W-1:0]  rr_ptr,
   output logic [PTR_W-1:0]  grant_idx,
   output logic              grant_any
);

   int idx;

   // Walk from the farthest candidate back to rr_ptr so the nearest set bit wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (pending[idx]) begin
            grant_idx = PTR_W'(idx);
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hearing_aid_channel_scheduler.sv
// Time-shares one audio processor between NUM_CH single-entry channel buffers,
// with round-robin issue, a processor-hang timeout and saturating status counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no sample in flight; grants the next pending channel, if any
//   WAIT  | sample issued; waiting for proc_ready or the timeout
module hearing_aid_channel_scheduler
   import hearing_aid_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH*DATA_W-1:0]   ch_in_data,
   input  logic [NUM_CH-1:0]          ch_in_valid,
   output logic [DATA_W-1:0]          proc_in,
   output logic                       proc_valid,
   input  logic [DATA_W-1:0]          proc_out,
   input  logic                       proc_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   output logic [$clog2(NUM_CH)-1:0]  out_ch,
   output logic                       out_timeout,
   output logic [NUM_CH*CNT_W-1:0]    overrun_cnt,
   output logic [CNT_W-1:0]           timeout_cnt,
   output logic                       busy
);

   localparam int PTR_W = $clog2(NUM_CH);
   localparam int WC_W  = $clog2(TIMEOUT);

   sched_state_t      state_q, state_d;
   logic [DATA_W-1:0] buf_q [NUM_CH];
   logic [DATA_W-1:0] buf_d [NUM_CH];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  cur_ch_q, cur_ch_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] proc_in_q, proc_in_d;
   logic              proc_valid_q, proc_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [PTR_W-1:0]  out_ch_q, out_ch_d;
   logic              out_timeout_q, out_timeout_d;
   logic [CNT_W-1:0]  overrun_q [NUM_CH];
   logic [CNT_W-1:0]  overrun_d [NUM_CH];
   logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;

   logic [PTR_W-1:0]  grant_idx;
   logic              grant_any;
   logic              consume;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W)
   ) u_arb (
      .pending   (pending_q),
      .rr_ptr    (rr_ptr_q),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      pending_d     = pending_q;
      rr_ptr_d      = rr_ptr_q;
      cur_ch_d      = cur_ch_q;
      wait_cnt_d    = wait_cnt_q;
      proc_in_d     = proc_in_q;
      proc_valid_d  = 1'b0;
      out_data_d    = out_data_q;
      out_valid_d   = 1'b0;
      out_ch_d      = out_ch_q;
      out_timeout_d = out_timeout_q;
      overrun_d     = overrun_q;
      timeout_cnt_d = timeout_cnt_q;
      consume       = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_any) begin
               consume              = 1'b1;
               proc_in_d            = buf_q[grant_idx];
               proc_valid_d         = 1'b1;
               cur_ch_d             = grant_idx;
               wait_cnt_d           = '0;
               pending_d[grant_idx] = 1'b0;
               rr_ptr_d             = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + PTR_W'(1);
               state_d              = WAIT;
            end
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
            // A late ready on the timeout edge still delivers real data.
            if (proc_ready) begin
               out_data_d    = proc_out;
               out_ch_d      = cur_ch_q;
               out_valid_d   = 1'b1;
               out_timeout_d = 1'b0;
               state_d       = IDLE;
            end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
               out_data_d    = '0;
               out_ch_d      = cur_ch_q;
               out_valid_d   = 1'b1;
               out_timeout_d = 1'b1;
               if (timeout_cnt_q != '1) begin
                  timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
               end
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // New samples land after the grant read the old buffer contents.
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_in_valid[i]) begin
            buf_d[i]     = ch_in_data[i*DATA_W +: DATA_W];
            pending_d[i] = 1'b1;
            if (pending_q[i] && !(consume && grant_idx == PTR_W'(i)) && overrun_q[i] != '1) begin
               overrun_d[i] = overrun_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pending_q     <= '0;
         rr_ptr_q      <= '0;
         cur_ch_q      <= '0;
         wait_cnt_q    <= '0;
         proc_in_q     <= '0;
         proc_valid_q  <= 1'b0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_ch_q      <= '0;
         out_timeout_q <= 1'b0;
         timeout_cnt_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            buf_q[i]     <= '0;
            overrun_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         rr_ptr_q      <= rr_ptr_d;
         cur_ch_q      <= cur_ch_d;
         wait_cnt_q    <= wait_cnt_d;
         proc_in_q     <= proc_in_d;
         proc_valid_q  <= proc_valid_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_ch_q      <= out_ch_d;
         out_timeout_q <= out_timeout_d;
         timeout_cnt_q <= timeout_cnt_d;
         buf_q         <= buf_d;
         overrun_q     <= overrun_d;
      end
   end

   assign proc_in     = proc_in_q;
   assign proc_valid  = proc_valid_q;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign out_ch      = out_ch_q;
   assign out_timeout = out_timeout_q;
   assign timeout_cnt = timeout_cnt_q;
   assign busy        = (state_q == WAIT);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ovr
      assign overrun_cnt[i*CNT_W +: CNT_W] = overrun_q[i];
   end

endmodule

// File: tb/tb_hearing_aid_channel_scheduler.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and a randomized run against a sample-level scheduler model.
module tb_hearing_aid_channel_scheduler;

   localparam int NUM_CH  = 2;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 8;
   localparam int LAT     = 3;

   logic                      clk;
   logic                      rst_n;
   logic [NUM_CH*DATA_W-1:0]  ch_in_data;
   logic [NUM_CH-1:0]         ch_in_valid;
   logic [DATA_W-1:0]         proc_in;
   logic                      proc_valid;
   logic [DATA_W-1:0]         proc_out;
   logic                      proc_ready;
   logic [DATA_W-1:0]         out_data;
   logic                      out_valid;
   logic [$clog2(NUM_CH)-1:0] out_ch;
   logic                      out_timeout;
   logic [NUM_CH*CNT_W-1:0]   overrun_cnt;
   logic [CNT_W-1:0]          timeout_cnt;
   logic                      busy;

   hearing_aid_channel_scheduler #(
      .NUM_CH (NUM_CH), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst_n (rst_n), .ch_in_data (ch_in_data), .ch_in_valid (ch_in_valid),
      .proc_in (proc_in), .proc_valid (proc_valid), .proc_out (proc_out), .proc_ready (proc_ready),
      .out_data (out_data), .out_valid (out_valid), .out_ch (out_ch), .out_timeout (out_timeout),
      .overrun_cnt (overrun_cnt), .timeout_cnt (timeout_cnt), .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Processor model: doubles the sample, ready LAT edges after the issue edge.
   int                       pcnt  = 0;
   bit                       stall = 1'b0;
   logic signed [DATA_W-1:0] plat  = '0;

   initial begin
      proc_ready = 1'b0;
      proc_out   = '0;
   end

   always @(posedge clk) begin
      #1;
      if (!rst_n) pcnt = 0;
      else if (proc_valid) begin
         pcnt = LAT;
         plat = proc_in;
      end else if (pcnt > 0) pcnt--;
      proc_ready = (pcnt == 1) && !stall;
      proc_out   = DATA_W'(2 * int'(plat));
   end

   task automatic do_reset();
      rst_n       = 1'b0;
      ch_in_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic strobe(input int ch, input int val);
      ch_in_data[ch*DATA_W +: DATA_W] = DATA_W'(val);
      ch_in_valid[ch] = 1'b1;
      @(posedge clk);
      #1;
      ch_in_valid = '0;
   endtask

   task automatic wait_out(input int budget, output int edges, output bit got, output int pv_edge);
      edges   = 0;
      got     = 1'b0;
      pv_edge = -1;
      while (edges < budget && !got) begin
         @(posedge clk);
         #1;
         edges++;
         if (proc_valid && pv_edge < 0) pv_edge = edges;
         if (out_valid) got = 1'b1;
      end
   endtask

   function automatic int all_or();
      return int'(|{proc_in, proc_valid, out_data, out_valid, out_ch, out_timeout, busy, overrun_cnt, timeout_cnt});
   endfunction

   function automatic int ovr(input int ch);
      return int'(overrun_cnt[ch*CNT_W +: CNT_W]);
   endfunction

   typedef struct {
      int ch;
      int din;
      int exp_data;
      int exp_ch;
   } vec_t;

   vec_t vecs[5];

   // Sample-level reference: channel buffers, round-robin pointer, issue/result timing.
   int m_buf[NUM_CH];
   bit m_pend[NUM_CH];
   int m_ovr[NUM_CH];
   int m_ptr, m_phase, m_cur_ch, m_cur_data;
   bit r_v[NUM_CH];
   int r_d[NUM_CH];

   task automatic model_step(output bit e_pv, output int e_pin, output bit e_ov,
                             output int e_och, output int e_odata);
      int g;
      g = -1;
      e_pv = 0; e_pin = 0; e_ov = 0; e_och = 0; e_odata = 0;
      if (m_phase == 0) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
         end
         if (g >= 0) begin
            e_pv       = 1;
            e_pin      = m_buf[g];
            m_cur_ch   = g;
            m_cur_data = m_buf[g];
            m_pend[g]  = 0;
            m_ptr      = (g + 1) % NUM_CH;
            m_phase    = LAT;
         end
      end else begin
         m_phase--;
         if (m_phase == 0) begin
            e_ov    = 1;
            e_och   = m_cur_ch;
            e_odata = 2 * m_cur_data;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_v[i]) begin
            if (m_pend[i] && g != i && m_ovr[i] < 255) m_ovr[i]++;
            m_buf[i]  = r_d[i];
            m_pend[i] = 1;
         end
      end
   endtask

   initial begin
      int  edges, pv_edge, missed, stale;
      bit  got;
      bit  e_pv, e_ov;
      int  e_pin, e_och, e_odata;

      vecs[0] = '{ch: 0, din: 100,    exp_data: 200,    exp_ch: 0};
      vecs[1] = '{ch: 1, din: -50,    exp_data: -100,   exp_ch: 1};
      vecs[2] = '{ch: 0, din: 0,      exp_data: 0,      exp_ch: 0};
      vecs[3] = '{ch: 1, din: 16383,  exp_data: 32766,  exp_ch: 1};
      vecs[4] = '{ch: 0, din: -16384, exp_data: -32768, exp_ch: 0};

      rst_n       = 1'b0;
      ch_in_valid = '0;
      ch_in_data  = '0;
      #2;
      check("reset_outputs_zero", all_or(), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed single samples
      foreach (vecs[v]) begin
         strobe(vecs[v].ch, vecs[v].din);
         wait_out(20, edges, got, pv_edge);
         check($sformatf("vec%0d_seen", v), int'(got), 1);
         check($sformatf("vec%0d_issue_edge", v), pv_edge, 1);
         check($sformatf("vec%0d_latency", v), edges, 4);
         check($sformatf("vec%0d_data", v), int'($signed(out_data)), vecs[v].exp_data);
         check($sformatf("vec%0d_ch", v), int'(out_ch), vecs[v].exp_ch);
         check($sformatf("vec%0d_timeout", v), int'(out_timeout), 0);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_one_cycle", v), int'(out_valid), 0);
      end

      // Fairness: both channels strobed together each round
      do_reset();
      for (int r = 0; r < 8; r++) begin
         ch_in_data  = {DATA_W'(20), DATA_W'(10)};
         ch_in_valid = 2'b11;
         @(posedge clk);
         #1;
         ch_in_valid = '0;
         for (int k = 0; k < 2; k++) begin
            wait_out(20, edges, got, pv_edge);
            check($sformatf("fair_r%0d_k%0d_seen", r, k), int'(got), 1);
            check($sformatf("fair_r%0d_k%0d_ch", r, k), int'(out_ch), k);
            check($sformatf("fair_r%0d_k%0d_data", r, k), int'($signed(out_data)), 20 * (k + 1));
         end
      end

      // Overrun, plus a same-edge reload of the channel being granted
      do_reset();
      strobe(0, 1);
      strobe(0, 3);
      strobe(1, 5);
      strobe(1, 7);
      for (int k = 0; k < 3; k++) begin
         wait_out(20, edges, got, pv_edge);
         check($sformatf("ovr_res%0d_seen", k), int'(got), 1);
         check($sformatf("ovr_res%0d_ch", k), int'(out_ch), (k == 1) ? 1 : 0);
         check($sformatf("ovr_res%0d_data", k), int'($signed(out_data)), (k == 0) ? 2 : (k == 1) ? 14 : 6);
      end
      check("ovr_cnt_ch0", ovr(0), 0);
      check("ovr_cnt_ch1", ovr(1), 1);

      // Timeout, then recovery
      do_reset();
      stall = 1'b1;
      strobe(0, 300);
      @(posedge clk);
      #1;
      check("to_busy_in_wait", int'(busy), 1);
      wait_out(100, edges, got, pv_edge);
      check("to_seen", int'(got), 1);
      check("to_latency", edges + 1, TIMEOUT + 1);
      check("to_flag", int'(out_timeout), 1);
      check("to_data", int'(out_data), 0);
      check("to_cnt", int'(timeout_cnt), 1);
      stall = 1'b0;
      @(posedge clk);
      #1;
      check("to_busy_after", int'(busy), 0);
      strobe(0, 7);
      wait_out(20, edges, got, pv_edge);
      check("to_next_seen", int'(got), 1);
      check("to_next_data", int'($signed(out_data)), 14);
      check("to_next_flag", int'(out_timeout), 0);
      check("to_next_cnt", int'(timeout_cnt), 1);

      // Counter saturation
      stall  = 1'b1;
      missed = 0;
      for (int n = 0; n < 300; n++) begin
         strobe(0, n);
         wait_out(100, edges, got, pv_edge);
         if (!got || !out_timeout) missed++;
      end
      stall = 1'b0;
      check("sat_all_timeouts", missed, 0);
      check("sat_timeout_cnt", int'(timeout_cnt), 255);

      // Reset while a sample is in flight
      do_reset();
      strobe(0, 100);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_wait_outputs_zero", all_or(), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stale = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid || proc_valid) stale++;
      end
      check("rst_no_stale", stale, 0);
      strobe(1, 50);
      wait_out(20, edges, got, pv_edge);
      check("rst_new_seen", int'(got), 1);
      check("rst_new_data", int'($signed(out_data)), 100);
      check("rst_new_ch", int'(out_ch), 1);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_buf[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_ptr = 0; m_phase = 0; m_cur_ch = 0; m_cur_data = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_v[i] = ($urandom_range(0, 99) < 25);
            r_d[i] = int'($urandom_range(0, 32767)) - 16384;
            ch_in_valid[i] = r_v[i];
            ch_in_data[i*DATA_W +: DATA_W] = DATA_W'(r_d[i]);
         end
         @(posedge clk);
         #1;
         model_step(e_pv, e_pin, e_ov, e_och, e_odata);
         check($sformatf("rnd%0d_proc_valid", cyc), int'(proc_valid), int'(e_pv));
         if (e_pv) check($sformatf("rnd%0d_proc_in", cyc), int'($signed(proc_in)), e_pin);
         check($sformatf("rnd%0d_out_valid", cyc), int'(out_valid), int'(e_ov));
         if (e_ov) begin
            check($sformatf("rnd%0d_out_ch", cyc), int'(out_ch), e_och);
            check($sformatf("rnd%0d_out_data", cyc), int'($signed(out_data)), e_odata);
            check($sformatf("rnd%0d_out_timeout", cyc), int'(out_timeout), 0);
         end
      end
      ch_in_valid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("rnd_overrun_ch%0d", i), ovr(i), m_ovr[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
